// File: rtl/chip8_pkg.sv
// Shared constants, FSM state type and the sprite mask helper for the CHIP-8 sprite engine.
package chip8_pkg;

  localparam int SCREEN_W  = 64;
  localparam int SCREEN_H  = 32;
  localparam int MAX_N     = 15;
  localparam int MMU_BUS_W = 8 * MAX_N;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAW,
    CLEAR,
    DONE
  } state_t;

  // Place a sprite byte at column x of a 64-bit row; bits shifted past column 63 fall off (clip).
  function automatic logic [SCREEN_W-1:0] sprite_mask(input logic [7:0] sprite_byte,
                                                      input logic [5:0] x);
    sprite_mask = {sprite_byte, {(SCREEN_W - 8){1'b0}}} >> x;
  endfunction

endpackage

// File: rtl/chip8_framebuffer.sv
// 32x64 monochrome framebuffer: one synchronous write port, one combinational read port
// for the draw datapath, and one combinational scan port for the display driver.
module chip8_framebuffer
  import chip8_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [4:0]          wr_row,
  input  logic [SCREEN_W-1:0] wr_data,
  input  logic [4:0]          rd_row,
  output logic [SCREEN_W-1:0] rd_data,
  input  logic [4:0]          scan_row,
  output logic [SCREEN_W-1:0] scan_data
);

  logic [SCREEN_W-1:0] fb [SCREEN_H];

  // Row storage; reset wipes the whole screen so a mid-draw abort leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < SCREEN_H; r++) begin
        fb[r] <= '0;
      end
    end else if (we) begin
      fb[wr_row] <= wr_data;
    end
  end

  assign rd_data   = fb[rd_row];
  assign scan_data = fb[scan_row];

endmodule

// File: rtl/chip8_sprite_draw.sv
// CHIP-8 DXYN / 00E0 engine: fetches sprite bytes over the mmu read bus with a single
// multi-byte read, XORs them into the framebuffer row by row and reports collision for VF.
module chip8_sprite_draw
  import chip8_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic [7:0]           x_in,
  input  logic [7:0]           y_in,
  input  logic [3:0]           n_in,
  input  logic [11:0]          i_addr,
  output logic                 mem_req,
  output logic [11:0]          mem_addr,
  output logic [3:0]           mem_len,
  input  logic [MMU_BUS_W-1:0] mem_data,
  output logic                 busy,
  output logic                 done,
  output logic                 collision,
  input  logic [4:0]           scan_row,
  output logic [SCREEN_W-1:0]  scan_data
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_LAT - 1);

  state_t state, state_nx;

  logic [5:0]           x_reg;
  logic [4:0]           y_reg;
  logic [3:0]           n_reg;
  logic [11:0]          i_reg;
  logic [MMU_BUS_W-1:0] sbuf;
  logic [3:0]           k_reg;
  logic [4:0]           row_cnt;
  logic [7:0]           wait_cnt;

  logic [5:0]           draw_row;
  logic [3:0]           byte_idx;
  logic [MMU_BUS_W-1:0] byte_shift;
  logic [7:0]           sprite_byte;
  logic [SCREEN_W-1:0]  mask;
  logic [SCREEN_W-1:0]  rd_data;
  logic                 row_hit;

  logic                 fb_we;
  logic [4:0]           fb_wr_row;
  logic [SCREEN_W-1:0]  fb_wr_data;

  logic                 accept;
  logic                 unused_ok;

  // Only the low bits of Vx/Vy matter: the start position wraps around the screen.
  assign unused_ok = ^{x_in[7:6], y_in[7:5]};

  assign accept = (state == IDLE) && (start || clear);

  // Draw datapath: byte k sits at sbuf[8*(n-k)-1 -: 8], so bytes above n are never selected.
  assign draw_row    = {1'b0, y_reg} + {2'b00, k_reg};
  assign byte_idx    = n_reg - k_reg - 4'd1;
  assign byte_shift  = sbuf >> {byte_idx, 3'b000};
  assign sprite_byte = byte_shift[7:0];
  assign mask        = sprite_mask(sprite_byte, x_reg);
  assign row_hit     = |(rd_data & mask);

  chip8_framebuffer u_fb (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (fb_we),
    .wr_row    (fb_wr_row),
    .wr_data   (fb_wr_data),
    .rd_row    (draw_row[4:0]),
    .rd_data   (rd_data),
    .scan_row  (scan_row),
    .scan_data (scan_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode plus framebuffer write control for DRAW (XOR) and CLEAR (zero fill).
  always_comb begin
    state_nx   = state;
    fb_we      = 1'b0;
    fb_wr_row  = draw_row[4:0];
    fb_wr_data = rd_data ^ mask;
    unique case (state)
      IDLE: begin
        if (clear) begin
          state_nx = CLEAR;
        end else if (start) begin
          state_nx = (n_in != 4'd0) ? REQ : DONE;
        end
      end
      REQ: begin
        state_nx = WAIT;
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nx = DRAW;
        end
      end
      DRAW: begin
        fb_we = !draw_row[5];
        if (k_reg == n_reg - 4'd1) begin
          state_nx = DONE;
        end
      end
      CLEAR: begin
        fb_we      = 1'b1;
        fb_wr_row  = row_cnt;
        fb_wr_data = '0;
        if (row_cnt == 5'(SCREEN_H - 1)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Operand latches, sprite buffer, row/wait counters and the sticky collision flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg     <= '0;
      y_reg     <= '0;
      n_reg     <= '0;
      i_reg     <= '0;
      sbuf      <= '0;
      k_reg     <= '0;
      row_cnt   <= '0;
      wait_cnt  <= '0;
      collision <= 1'b0;
    end else begin
      if (accept) begin
        x_reg     <= x_in[5:0];
        y_reg     <= y_in[4:0];
        n_reg     <= n_in;
        i_reg     <= i_addr;
        k_reg     <= '0;
        row_cnt   <= '0;
        wait_cnt  <= '0;
        collision <= 1'b0;
      end
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
        if (wait_cnt == WAIT_LAST) begin
          sbuf  <= mem_data;
          k_reg <= '0;
        end
      end
      if (state == DRAW) begin
        k_reg <= k_reg + 4'd1;
        if (!draw_row[5]) begin
          collision <= collision | row_hit;
        end
      end
      if (state == CLEAR) begin
        row_cnt <= row_cnt + 5'd1;
      end
    end
  end

  assign mem_req  = (state == REQ) || (state == WAIT);
  assign mem_addr = mem_req ? i_reg : 12'd0;
  assign mem_len  = mem_req ? n_reg : 4'd0;
  assign busy     = (state == REQ) || (state == WAIT) || (state == DRAW) || (state == CLEAR);
  assign done     = (state == DONE);

endmodule
